spi_eeprom_responder: RTL and testbench



---
 rtl/spi_eeprom_pkg.sv | 35 +++
 rtl/spi_pin_sync.sv | 42 ++++
 rtl/spi_eeprom_responder.sv | 212 +++++++++++++++++++++
 tb/tb_spi_eeprom_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM responder: opcodes, FSM states and
// status register layout.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  // Bit positions inside the status register.
  localparam int STATUS_WIP = 0;
  localparam int STATUS_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_READ_DATA,
    ST_WRITE_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  // Status byte {6'b0, WEL, WIP}; WIP is constant 0 since writes take one clk.
  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s             = '0;
    s[STATUS_WEL] = wel;
    s[STATUS_WIP] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain through two flops and
// detects spi_clk / ss edges against a third flop.
module spi_pin_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic ss,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  // Synchronizer chains; bit 1 is the synchronized level, bit 2 the edge reference.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples the pre-edge value.
    if (!reset) begin
      sclk_q <= '0;
      // ss flops clear to low: if ss is still low after a reset no falling edge
      // is seen, so the FSM waits for ss to go high before a fresh transaction.
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      ss_q   <= {ss_q[1:0], ss};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a small M95xxx-style EEPROM: READ, WRITE,
// WREN, WRDI and RDSR, with a clk-domain preload port for boot images.
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int PAGE_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        busy
);

  localparam int            AW        = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift_in, shift_in_n;
  logic [7:0]    shift_out, shift_out_n;
  logic [7:0]    addr_hi, addr_hi_n;
  logic [AW-1:0] addr, addr_n;
  logic          wel, wel_n;
  logic          is_write, is_write_n;
  logic          wr_ok, wr_ok_n;
  logic          miso_q, miso_n;
  logic          oe_q, oe_n;
  logic          spi_we;

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic [AW-1:0] addr_start, addr_seq, addr_page;

  logic [7:0]    mem [MEM_DEPTH];

  spi_pin_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .ss        (ss),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .mosi_s    (mosi_s)
  );

  // Byte being completed by the current rising edge, and the address forms.
  assign rx_byte    = {shift_in[6:0], mosi_s};
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
  assign addr_start = AW'({addr_hi, rx_byte});
  assign addr_seq   = addr + AW'(1);
  assign addr_page  = (addr & ~PAGE_MASK) | (addr_seq & PAGE_MASK);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      addr_hi   <= '0;
      addr      <= '0;
      wel       <= 1'b0;
      is_write  <= 1'b0;
      wr_ok     <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_in  <= shift_in_n;
      shift_out <= shift_out_n;
      addr_hi   <= addr_hi_n;
      addr      <= addr_n;
      wel       <= wel_n;
      is_write  <= is_write_n;
      wr_ok     <= wr_ok_n;
      miso_q    <= miso_n;
      oe_q      <= oe_n;
    end
  end

  // Next-state and datapath decode driven by the detected pin edges.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_in_n  = shift_in;
    shift_out_n = shift_out;
    addr_hi_n   = addr_hi;
    addr_n      = addr;
    wel_n       = wel;
    is_write_n  = is_write;
    wr_ok_n     = wr_ok;
    miso_n      = miso_q;
    oe_n        = oe_q;
    spi_we      = 1'b0;

    if (ss_rise) begin
      // Deselect aborts anything in flight; a partial byte is simply dropped.
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      miso_n    = 1'b0;
      oe_n      = 1'b0;
      wr_ok_n   = 1'b0;
      if (wr_ok) wel_n = 1'b0;
    end else if (state == ST_IDLE) begin
      if (ss_fall) begin
        state_n    = ST_CMD;
        bit_cnt_n  = '0;
        is_write_n = 1'b0;
        wr_ok_n    = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        shift_in_n = rx_byte;
        bit_cnt_n  = bit_cnt + 3'd1;
      end

      if (sclk_fall && (state == ST_READ_DATA || state == ST_STATUS)) begin
        miso_n      = shift_out[7];
        oe_n        = 1'b1;
        shift_out_n = {shift_out[6:0], 1'b0};
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            case (rx_byte)
              OP_WREN: begin
                wel_n   = 1'b1;
                state_n = ST_IGNORE;
              end
              OP_WRDI: begin
                wel_n   = 1'b0;
                state_n = ST_IGNORE;
              end
              OP_RDSR: begin
                shift_out_n = status_byte(wel);
                state_n     = ST_STATUS;
              end
              OP_READ: begin
                is_write_n = 1'b0;
                state_n    = ST_ADDR_HI;
              end
              OP_WRITE: begin
                if (wel) begin
                  is_write_n = 1'b1;
                  wr_ok_n    = 1'b1;
                  state_n    = ST_ADDR_HI;
                end else begin
                  state_n = ST_IGNORE;
                end
              end
              default: state_n = ST_IGNORE;
            endcase
          end
          ST_ADDR_HI: begin
            addr_hi_n = rx_byte;
            state_n   = ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            addr_n = addr_start;
            if (is_write) begin
              state_n = ST_WRITE_DATA;
            end else begin
              shift_out_n = mem[addr_start];
              state_n     = ST_READ_DATA;
            end
          end
          ST_READ_DATA: begin
            addr_n      = addr_seq;
            shift_out_n = mem[addr_seq];
          end
          ST_WRITE_DATA: begin
            spi_we = 1'b1;
            addr_n = addr_page;
          end
          ST_STATUS: shift_out_n = status_byte(wel);
          default: ;
        endcase
      end
    end
  end

  // Single write port shared by SPI and preload; SPI takes priority.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; its contents must survive reset and a reset would block RAM inference.
    if (reset && spi_we) begin
      mem[addr] <= rx_byte;
    end else if (load_en) begin
      mem[AW'(load_addr)] <= load_data;
    end
  end

  assign miso    = miso_q & oe_q;
  assign miso_oe = oe_q;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Scoreboard bench for spi_eeprom_responder: stimulus pushes the bytes the
// master should receive, a monitor assembles MISO bytes and compares them.
module tb_spi_eeprom_responder;

  localparam int HALF = 100;  // SPI half period: 10 clk periods

  logic        clk;
  logic        reset;
  logic        spi_clk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        load_en;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;

  int          n_vec;
  int          n_miss;
  logic [7:0]  sb[$];
  logic [7:0]  mon_shift;
  int          mon_bits;
  logic [7:0]  exp_b;

  spi_eeprom_responder #(.MEM_DEPTH(256), .PAGE_SIZE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_clk   (spi_clk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the master samples MISO on each rising spi_clk while the block drives it.
  initial begin
    mon_bits  = 0;
    mon_shift = '0;
  end
  always @(posedge spi_clk or posedge ss) begin
    if (ss) begin
      mon_bits = 0;
    end else if (miso_oe) begin
      mon_shift = {mon_shift[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_byte: got 0x%02h, no byte expected", mon_shift);
        end else begin
          exp_b = sb.pop_front();
          check("miso_byte", {8'h00, mon_shift}, {8'h00, exp_b});
        end
      end
    end
  end

  task automatic spi_bit(input logic b);
    mosi = b;
    #HALF;
    spi_clk = 1'b1;
    #HALF;
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic ss_begin();
    @(posedge clk);
    #2;
    ss = 1'b0;
    #HALF;
  endtask

  // Deselect, let the block settle, and require every expected byte to have arrived.
  task automatic ss_end();
    #HALF;
    ss = 1'b1;
    #(HALF * 2);
    check("sb_drain", 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  task automatic cmd_txn(input logic [7:0] op);
    ss_begin();
    spi_byte(op);
    ss_end();
  endtask

  task automatic read_txn(input logic [15:0] a, input int nbytes);
    ss_begin();
    spi_byte(8'h03);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
    repeat (nbytes) spi_byte(8'h00);
    ss_end();
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
    ss_begin();
    spi_byte(8'h02);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
    spi_byte(d0);
    spi_byte(d1);
    ss_end();
  endtask

  task automatic rdsr_txn(input int nbytes);
    ss_begin();
    spi_byte(8'h05);
    repeat (nbytes) spi_byte(8'h00);
    ss_end();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    #2;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #2;
    load_en = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo;
    n_vec     = 0;
    n_miss    = 0;
    reset     = 1'b0;
    ss        = 1'b1;
    spi_clk   = 1'b0;
    mosi      = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;

    #2;
    repeat (5) @(posedge clk);
    #2;
    check("reset_miso", {15'd0, miso}, 16'd0);
    check("reset_oe", {15'd0, miso_oe}, 16'd0);
    check("reset_busy", {15'd0, busy}, 16'd0);
    reset = 1'b1;

    preload(16'h0010, 8'hA5);
    preload(16'h0011, 8'h3C);
    preload(16'h00FF, 8'h5A);
    preload(16'h0000, 8'h96);
    preload(16'h000F, 8'hC3);
    repeat (5) @(posedge clk);

    // READ 0x0010, two bytes, with miso_oe timing around the 24th falling edge.
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    ss_begin();
    check("busy_selected", {15'd0, busy}, 16'd1);
    spi_byte(8'h03);
    spi_byte(8'h00);
    lo = 8'h10;
    for (int i = 7; i >= 1; i--) spi_bit(lo[i]);
    mosi = lo[0];
    #HALF;
    spi_clk = 1'b1;
    #HALF;
    check("oe_before_fall24", {15'd0, miso_oe}, 16'd0);
    spi_clk = 1'b0;
    #60;
    check("oe_after_fall24", {15'd0, miso_oe}, 16'd1);
    check("first_bit", {15'd0, miso}, 16'd1);
    spi_byte(8'h00);
    spi_byte(8'h00);
    ss_end();
    check("busy_deselected", {15'd0, busy}, 16'd0);

    // Address wrap from 0xFF to 0x00.
    sb.push_back(8'h5A);
    sb.push_back(8'h96);
    read_txn(16'h00FF, 2);

    // Address bits above the memory size are ignored.
    sb.push_back(8'hA5);
    read_txn(16'h3410, 1);

    // WRITE without WREN leaves memory untouched; reads run across the page.
    write_txn(16'h000F, 8'h11, 8'h22);
    sb.push_back(8'hC3);
    sb.push_back(8'hA5);
    read_txn(16'h000F, 2);

    // WREN then WRITE wraps inside the page; WEL clears afterwards.
    cmd_txn(8'h06);
    write_txn(16'h000F, 8'h11, 8'h22);
    sb.push_back(8'h00);
    rdsr_txn(1);
    sb.push_back(8'h11);
    sb.push_back(8'hA5);
    read_txn(16'h000F, 2);
    sb.push_back(8'h22);
    read_txn(16'h0000, 1);

    // Status register follows WREN / WRDI.
    cmd_txn(8'h06);
    sb.push_back(8'h02);
    sb.push_back(8'h02);
    sb.push_back(8'h02);
    rdsr_txn(3);
    cmd_txn(8'h04);
    sb.push_back(8'h00);
    rdsr_txn(1);

    // Unknown opcode produces no output.
    ss_begin();
    spi_byte(8'h9F);
    spi_byte(8'h00);
    ss_end();

    // Partial WRITE byte is discarded; the accepted write still clears WEL.
    cmd_txn(8'h06);
    ss_begin();
    spi_byte(8'h02);
    spi_byte(8'h00);
    spi_byte(8'h10);
    repeat (5) spi_bit(1'b1);
    ss_end();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    read_txn(16'h0010, 2);
    sb.push_back(8'h00);
    rdsr_txn(1);

    // Reset pulse in the middle of a READ data byte.
    ss_begin();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h10);
    spi_bit(1'b0);
    spi_bit(1'b0);
    #60;
    check("oe_before_reset", {15'd0, miso_oe}, 16'd1);
    check("miso_before_reset", {15'd0, miso}, 16'd1);
    reset = 1'b0;
    #10;
    check("oe_after_reset", {15'd0, miso_oe}, 16'd0);
    check("miso_after_reset", {15'd0, miso}, 16'd0);
    check("busy_after_reset", {15'd0, busy}, 16'd0);
    reset = 1'b1;
    repeat (3) spi_bit(1'b0);
    ss_end();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    read_txn(16'h0010, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
